uart_tx: RTL and testbench

- Serial UART transmitter that pairs with the UART receiver path.
- Accepts a parallel byte with a valid strobe, latches it together with the frame configuration, and shifts out start, data (LSB first), optional parity and stop bits on TX_OUT.
- Each bit is held for Prescale clock cycles, so a shared CLK and Prescale setting gives bit-rate parity with the receiver.
- Sits in the UART top beside the RX path and is driven by the register/system controller.

---
 rtl/uart_tx_pkg.sv | 27 ++
 rtl/uart_tx_bit_timer.sv | 56 +++++
 rtl/uart_tx.sv | 190 +++++++++++++++++++
 tb/tb_uart_tx.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg
//   Shared definitions for the UART transmitter: FSM state encoding,
//   parity-type constants, line levels and the minimum prescale value.
//   Imported by uart_tx and uart_tx_bit_timer.
package uart_tx_pkg;

    // Frame FSM states; explicit encodings keep the legacy state values.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // PAR_TYP encodings
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Serial line levels
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // Smallest supported clocks-per-bit; requests of 0 or 1 are raised to this.
    localparam int PRESCALE_MIN = 2;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// uart_tx_bit_timer
//   Bit timing for the UART transmitter. A cycle counter runs
//   0..prescale-1 for every bit on the line and a bit index counts the data
//   bits 0..DATA_WIDTH-1 while the FSM is in DATA.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   prescale      in   latched clocks-per-bit (already clamped to >= 2)
//   restart       in   frame load: zero both counters
//   active        in   FSM is not IDLE: cycle counter runs
//   in_data       in   FSM is in DATA: bit index advances on bit_done
//   bit_done      out  current bit has been held for prescale cycles
//   last_data_bit out  bit index is at DATA_WIDTH-1
module uart_tx_bit_timer
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  restart,
    input  logic                  active,
    input  logic                  in_data,
    output logic                  bit_done,
    output logic                  last_data_bit
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [PRESCALE_W-1:0] cnt_q;
    logic [IDX_W-1:0]      idx_q;

    assign bit_done      = active && (cnt_q == (prescale - PRESCALE_W'(1)));
    assign last_data_bit = (idx_q == IDX_W'(DATA_WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else if (restart) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            if (active) begin
                cnt_q <= bit_done ? '0 : cnt_q + PRESCALE_W'(1);
            end
            if (in_data && bit_done) begin
                idx_q <= last_data_bit ? '0 : idx_q + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx
//   UART transmitter. Accepts a byte on DATA_VALID && DATA_READY, latches
//   it with the frame configuration and sends start, data (LSB first),
//   optional parity and stop bits, each held for Prescale clock cycles.
//   All outputs are registered.
//
// Ports:
//   CLK        in   system clock, rising edge
//   RST        in   asynchronous active-low reset
//   P_DATA     in   byte to transmit, sampled on accept
//   DATA_VALID in   transmit request, accepted when DATA_READY=1
//   PAR_EN     in   1 = append parity bit, sampled on accept
//   PAR_TYP    in   0 = even, 1 = odd, sampled on accept
//   Prescale   in   clocks per bit (0 and 1 act as 2), sampled on accept
//   TX_OUT     out  serial line, idles high
//   busy       out  high while a frame is on the line
//   DATA_READY out  a new byte can be accepted
//
// Build option:
//   UART_TX_HOLD_BUF_EN  adds a one-entry holding buffer so the next byte can
//                        be accepted mid-frame and sent back-to-back.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic                  DATA_READY
);

    tx_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_bit_q, par_bit_d;
    logic                  par_en_q, par_en_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  busy_d, ready_d, tx_d;

    logic                  accept, load, stop_done;
    logic                  bit_done, last_data_bit;
    logic [DATA_WIDTH-1:0] src_data;
    logic                  src_par_en, src_par_typ;
    logic [PRESCALE_W-1:0] src_prescale;

    function automatic logic [PRESCALE_W-1:0] clamp_prescale(input logic [PRESCALE_W-1:0] p);
        return (p < PRESCALE_W'(PRESCALE_MIN)) ? PRESCALE_W'(PRESCALE_MIN) : p;
    endfunction

    assign accept    = DATA_VALID && DATA_READY;
    assign stop_done = (state_q == STOP) && bit_done;

    uart_tx_bit_timer #(
        .DATA_WIDTH (DATA_WIDTH),
        .PRESCALE_W (PRESCALE_W)
    ) u_bit_timer (
        .clk           (CLK),
        .rst_n         (RST),
        .prescale      (prescale_q),
        .restart       (load),
        .active        (state_q != IDLE),
        .in_data       (state_q == DATA),
        .bit_done      (bit_done),
        .last_data_bit (last_data_bit)
    );

`ifdef UART_TX_HOLD_BUF_EN
    logic                  hb_valid_q, hb_valid_d;
    logic [DATA_WIDTH-1:0] hb_data_q;
    logic                  hb_par_en_q, hb_par_typ_q;
    logic [PRESCALE_W-1:0] hb_prescale_q;
    logic                  load_from_hb, load_from_in, hb_wr;

    // A byte goes straight to the working registers when the line is idle,
    // or when STOP ends with an empty buffer (otherwise it would be parked
    // in the buffer with nothing left to drain it). Everything else is
    // parked; a simultaneous drain takes the old entry, so the buffer stays
    // full.
    always_comb begin
        load_from_hb = stop_done && hb_valid_q;
        load_from_in = accept && ((state_q == IDLE) || (stop_done && !hb_valid_q));
        hb_wr        = accept && !load_from_in;
        hb_valid_d   = hb_wr || (hb_valid_q && !load_from_hb);
        load         = load_from_hb || load_from_in;
        if (load_from_hb) begin
            src_data     = hb_data_q;
            src_par_en   = hb_par_en_q;
            src_par_typ  = hb_par_typ_q;
            src_prescale = hb_prescale_q;
        end else begin
            src_data     = P_DATA;
            src_par_en   = PAR_EN;
            src_par_typ  = PAR_TYP;
            src_prescale = clamp_prescale(Prescale);
        end
        ready_d = !hb_valid_d;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hb_valid_q    <= 1'b0;
            hb_data_q     <= '0;
            hb_par_en_q   <= 1'b0;
            hb_par_typ_q  <= 1'b0;
            hb_prescale_q <= '0;
        end else begin
            hb_valid_q <= hb_valid_d;
            if (hb_wr) begin
                hb_data_q     <= P_DATA;
                hb_par_en_q   <= PAR_EN;
                hb_par_typ_q  <= PAR_TYP;
                hb_prescale_q <= clamp_prescale(Prescale);
            end
        end
    end
`else
    always_comb begin
        load         = accept && (state_q == IDLE);
        src_data     = P_DATA;
        src_par_en   = PAR_EN;
        src_par_typ  = PAR_TYP;
        src_prescale = clamp_prescale(Prescale);
        ready_d      = !busy_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load) state_d = START;
            START:   if (bit_done) state_d = DATA;
            DATA:    if (bit_done && last_data_bit) state_d = par_en_q ? PARITY : STOP;
            PARITY:  if (bit_done) state_d = STOP;
            STOP:    if (bit_done) state_d = load ? START : IDLE;
            default: state_d = IDLE;
        endcase

        if (load) begin
            shift_d    = src_data;
            par_bit_d  = (^src_data) ^ (src_par_typ == PAR_ODD);
            par_en_d   = src_par_en;
            prescale_d = src_prescale;
        end else begin
            shift_d    = (state_q == DATA && bit_done) ? (shift_q >> 1) : shift_q;
            par_bit_d  = par_bit_q;
            par_en_d   = par_en_q;
            prescale_d = prescale_q;
        end

        busy_d = load || (busy && !stop_done);

        // TX_OUT is registered, so it is decoded from the next state.
        case (state_d)
            START:   tx_d = START_LEVEL;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_bit_d;
            default: tx_d = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            par_en_q   <= 1'b0;
            prescale_q <= '0;
            TX_OUT     <= IDLE_LEVEL;
            busy       <= 1'b0;
            DATA_READY <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            par_bit_q  <= par_bit_d;
            par_en_q   <= par_en_d;
            prescale_q <= prescale_d;
            TX_OUT     <= tx_d;
            busy       <= busy_d;
            DATA_READY <= ready_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx
//   Directed self-checking bench for uart_tx. Expected line sequences are
//   hand-computed bit vectors (bit i = i-th bit on the line, start first).
//   Build option: UART_TX_HOLD_BUF_EN selects the holding-buffer scenario.
module tb_uart_tx;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] P_DATA = '0;
    logic       DATA_VALID = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [5:0] Prescale = '0;
    logic       TX_OUT, busy, DATA_READY;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .TX_OUT     (TX_OUT),
        .busy       (busy),
        .DATA_READY (DATA_READY)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Waits (bounded) for DATA_READY, then presents one byte for one edge.
    // Returns at the sample point just after the accept edge.
    task automatic accept_byte(input logic [7:0] d, input logic pe, input logic pt,
                               input logic [5:0] ps, input string nm, output bit ok);
        int w = 0;
        while (DATA_READY !== 1'b1 && w < 50) begin
            step();
            w++;
        end
        n_cmp++;
        if (DATA_READY !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_ready_wait: DATA_READY=%b after %0d cycles, want 1", nm, DATA_READY, w);
            ok = 0;
            return;
        end
        P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Prescale = ps; DATA_VALID = 1'b1;
        step();
        DATA_VALID = 1'b0;
        // Scramble the sampled-on-accept inputs to prove they are latched.
        P_DATA = ~d; PAR_EN = ~pe; PAR_TYP = ~pt; Prescale = ps + 6'd3;
        ok = 1;
    endtask

    // Sends one frame and checks every line cycle, busy length and the
    // idle state afterwards. pulse_at >= 0 injects a DATA_VALID(0x3C) pulse.
    task automatic run_frame(input logic [7:0] d, input logic pe, input logic pt,
                             input logic [5:0] ps, input logic [31:0] exp_bits,
                             input int nbits, input int eff, input int exp_busy,
                             input int pulse_at, input string nm);
        bit ok;
        int bad_line = 0, first_bad = -1, busy_len = 0, rdy_bad = 0;
        accept_byte(d, pe, pt, ps, nm, ok);
        if (!ok) return;
        for (int c = 0; c < nbits * eff; c++) begin
            if (c == pulse_at) begin
                P_DATA = 8'h3C; DATA_VALID = 1'b1;
            end else if (c == pulse_at + 1) begin
                DATA_VALID = 1'b0;
            end
            if (TX_OUT !== exp_bits[c / eff]) begin
                bad_line++;
                if (first_bad < 0) first_bad = c;
            end
            if (busy === 1'b1) busy_len++;
`ifndef UART_TX_HOLD_BUF_EN
            if (DATA_READY !== 1'b0) rdy_bad++;
`endif
            step();
        end
        n_cmp++;
        if (bad_line != 0) begin
            n_bad++;
            $display("FAIL %s_line: %0d wrong cycles (first at cycle %0d), want 0", nm, bad_line, first_bad);
        end
        n_cmp++;
        if (busy_len != exp_busy) begin
            n_bad++;
            $display("FAIL %s_busy_len: got %0d cycles, want %0d", nm, busy_len, exp_busy);
        end
`ifndef UART_TX_HOLD_BUF_EN
        n_cmp++;
        if (rdy_bad != 0) begin
            n_bad++;
            $display("FAIL %s_ready_low: DATA_READY high in %0d busy cycles, want 0", nm, rdy_bad);
        end
`endif
        n_cmp++;
        if ({busy, TX_OUT, DATA_READY} !== 3'b011) begin
            n_bad++;
            $display("FAIL %s_end: busy,TX_OUT,DATA_READY=%b%b%b, want 011", nm, busy, TX_OUT, DATA_READY);
        end
    endtask

    task automatic test_reset();
        RST = 1'b0;
        step(); step();
        n_cmp++;
        if ({TX_OUT, busy, DATA_READY} !== 3'b100) begin
            n_bad++;
            $display("FAIL reset_state: TX_OUT,busy,DATA_READY=%b%b%b, want 100", TX_OUT, busy, DATA_READY);
        end
        RST = 1'b1;
        #1;
        n_cmp++;
        if (DATA_READY !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release_ready: got %b, want 0", DATA_READY);
        end
        step();
        n_cmp++;
        if (DATA_READY !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_first_edge_ready: got %b, want 1", DATA_READY);
        end
    endtask

    task automatic test_frame_a5_even();
        // 0xA5, even parity 0: 0,1,0,1,0,0,1,0,1,0,1
        run_frame(8'hA5, 1'b1, 1'b0, 6'd8, 32'b101_0100_1010, 11, 8, 88, -1, "a5_even");
    endtask

    task automatic test_frame_07_variants();
        // 0x07 no parity: 0,1,1,1,0,0,0,0,0,1
        run_frame(8'h07, 1'b0, 1'b0, 6'd16, 32'b10_0000_1110, 10, 16, 160, -1, "07_nopar");
        // 0x07 odd parity -> 0
        run_frame(8'h07, 1'b1, 1'b1, 6'd16, 32'b100_0000_1110, 11, 16, 176, -1, "07_odd");
        // 0x07 even parity -> 1
        run_frame(8'h07, 1'b1, 1'b0, 6'd16, 32'b110_0000_1110, 11, 16, 176, -1, "07_even");
    endtask

    task automatic test_prescale_clamp();
        // Prescale 0 -> 2 cycles/bit; 0x5A no parity: 0,0,1,0,1,1,0,1,0,1
        run_frame(8'h5A, 1'b0, 1'b0, 6'd0, 32'b10_1011_0100, 10, 2, 20, -1, "ps0");
        // Prescale 1 -> 2 cycles/bit; 0xFF even parity 0
        run_frame(8'hFF, 1'b1, 1'b0, 6'd1, 32'b101_1111_1110, 11, 2, 22, -1, "ps1");
    endtask

`ifndef UART_TX_HOLD_BUF_EN
    task automatic test_ignore_mid_frame();
        int busy_seen = 0;
        run_frame(8'hA5, 1'b1, 1'b0, 6'd8, 32'b101_0100_1010, 11, 8, 88, 20, "ignore");
        for (int c = 0; c < 30; c++) begin
            if (busy !== 1'b0 || TX_OUT !== 1'b1) busy_seen++;
            step();
        end
        n_cmp++;
        if (busy_seen != 0) begin
            n_bad++;
            $display("FAIL ignore_no_second_frame: %0d non-idle cycles, want 0", busy_seen);
        end
    endtask
`endif

    task automatic test_reset_mid_frame();
        bit ok;
        accept_byte(8'hA5, 1'b1, 1'b0, 6'd8, "rst_mid", ok);
        if (ok) begin
            for (int c = 0; c < 30; c++) step();
            #4;
            RST = 1'b0;
            #1;
            n_cmp++;
            if ({TX_OUT, busy, DATA_READY} !== 3'b100) begin
                n_bad++;
                $display("FAIL rst_mid_async: TX_OUT,busy,DATA_READY=%b%b%b, want 100", TX_OUT, busy, DATA_READY);
            end
            step();
            RST = 1'b1;
            step();
        end
        run_frame(8'hA5, 1'b1, 1'b0, 6'd8, 32'b101_0100_1010, 11, 8, 88, -1, "after_rst");
    endtask

`ifdef UART_TX_HOLD_BUF_EN
    task automatic test_back_to_back();
        bit ok;
        logic [31:0] exp_bits = {12'd0, 10'b11_0101_0100, 10'b10_1010_1010};
        int bad_line = 0, first_bad = -1, busy_low = 0;
        logic rdy11 = 1'bx, rdy39 = 1'bx, rdy40 = 1'bx;
        accept_byte(8'h55, 1'b0, 1'b0, 6'd4, "b2b", ok);
        if (!ok) return;
        for (int c = 0; c < 80; c++) begin
            if (c == 10) begin
                P_DATA = 8'hAA; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd4; DATA_VALID = 1'b1;
            end else if (c == 11) begin
                DATA_VALID = 1'b0; P_DATA = 8'h00; Prescale = 6'd9;
            end
            if (c == 11) rdy11 = DATA_READY;
            if (c == 39) rdy39 = DATA_READY;
            if (c == 40) rdy40 = DATA_READY;
            if (TX_OUT !== exp_bits[c / 4]) begin
                bad_line++;
                if (first_bad < 0) first_bad = c;
            end
            if (busy !== 1'b1) busy_low++;
            step();
        end
        n_cmp++;
        if (bad_line != 0) begin
            n_bad++;
            $display("FAIL b2b_line: %0d wrong cycles (first at cycle %0d), want 0", bad_line, first_bad);
        end
        n_cmp++;
        if (busy_low != 0) begin
            n_bad++;
            $display("FAIL b2b_busy_gap: busy low in %0d cycles, want 0", busy_low);
        end
        n_cmp++;
        if ({rdy11, rdy39, rdy40} !== 3'b001) begin
            n_bad++;
            $display("FAIL b2b_ready: DATA_READY at 11,39,40=%b%b%b, want 001", rdy11, rdy39, rdy40);
        end
        n_cmp++;
        if ({busy, TX_OUT} !== 2'b01) begin
            n_bad++;
            $display("FAIL b2b_end: busy,TX_OUT=%b%b, want 01", busy, TX_OUT);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_frame_a5_even();
        test_frame_07_variants();
        test_prescale_clamp();
`ifndef UART_TX_HOLD_BUF_EN
        test_ignore_mid_frame();
`else
        test_back_to_back();
`endif
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
